instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have: clk  input  1  system clock, rising-edge active.
REQ-002 SHALL have: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: pc  input  32  word address from program counter unit (pc+1 = next word).
REQ-004 SHALL have: instr  output  32  instruction to PC unit/decoder; 32'h0 (NOP) when no instruction delivered.
REQ-005 SHALL have: stall  output  1  1 = PC unit must hold pc.
REQ-006 SHALL have: imem_req  output  1  read request to instruction memory.
REQ-007 SHALL have: imem_addr  output  32  registered word address of current request.
REQ-008 SHALL have: imem_ack  input  1  memory response valid.
REQ-009 SHALL have: imem_rdata  input  32  memory read data, valid when imem_ack=1.
REQ-010 SHALL have: fetch_err  output  1  sticky timeout flag.
REQ-011 SHALL have: fetch_cnt  output  32  count of instructions delivered from memory.
REQ-012 SHALL have parameter: TIMEOUT, default 15, max wait cycles before abort.

Function
REQ-013 SHALL implement FSM with states ISSUE, WAIT, DELIVER; all outputs registered.
REQ-014 ISSUE: at next edge SHALL set imem_addr<=pc, imem_req<=1, wait counter<=0, go WAIT; instr=0, stall=1.
REQ-015 WAIT: imem_req SHALL stay 1 and imem_addr stable until imem_ack sampled 1 or timeout.
REQ-016 WAIT with imem_ack=1: at edge instr<=imem_rdata, stall<=0, imem_req<=0, fetch_cnt<=fetch_cnt+1, go DELIVER.
REQ-017 WAIT without ack: wait counter SHALL increment each cycle; when counter = TIMEOUT-1 and no ack, at edge instr<=0, stall<=0, imem_req<=0, fetch_err<=1, go DELIVER; fetch_cnt unchanged.
REQ-018 Ack in the same cycle as timeout SHALL win (treated as REQ-016, no error).
REQ-019 DELIVER: lasts exactly 1 cycle; at edge instr<=0, stall<=1, go ISSUE (pc sampled next ISSUE is post-update value).
REQ-020 Minimum throughput: 3 cycles per instruction (ISSUE, 1 WAIT cycle, DELIVER) when memory acks in first WAIT cycle.
REQ-021 instr SHALL be 32'h0 in every cycle where stall=1, so no branch/jump/jr is presented while PC is held.
REQ-022 imem_ack in ISSUE or DELIVER SHALL be ignored (no data capture, no count).
REQ-023 pc changes during WAIT SHALL be ignored; the latched imem_addr fetch completes.
REQ-024 fetch_cnt SHALL wrap 32'hFFFFFFFF -> 0 silently.
REQ-025 fetch_err SHALL remain 1 until reset.

Reset
REQ-026 rst_n=0 SHALL immediately force: state ISSUE, instr=0, stall=1, imem_req=0, imem_addr=0, fetch_err=0, fetch_cnt=0, wait counter=0.
REQ-027 Reset asserted mid-WAIT SHALL drop imem_req at once; a later ack for the aborted request SHALL be ignored per REQ-022.
REQ-028 First request after reset release SHALL use pc sampled in the first ISSUE cycle (0 from PC unit).

Verification
REQ-029 Zero-wait memory: pc=0, mem[0]=32'h20080005, ack in first WAIT cycle -> instr=32'h20080005 for 1 cycle at cycle 3, stall=0 that cycle, fetch_cnt=1.
REQ-030 Delayed ack: ack after 4 WAIT cycles -> imem_req high 4 cycles, imem_addr stable, stall=1 and instr=0 throughout, then 1-cycle delivery.
REQ-031 Timeout: TIMEOUT=15, ack never -> after 15 WAIT cycles instr=0, stall=0 one cycle, fetch_err=1 sticky, fetch_cnt unchanged, next ISSUE starts.
REQ-032 Ack on timeout cycle: ack in 15th WAIT cycle with rdata=32'h00000001 -> delivered, fetch_err stays 0.
REQ-033 Branch sequence with PC unit: beq taken at pc=4 offset 3 -> next imem_addr=8 (no double-branch while stalled, instr=0 during stall).
REQ-034 Reset mid-WAIT with pending ack next cycle -> imem_req=0 immediately, stray ack ignored, fetch_cnt=0, first new imem_addr=0.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch FSM between PC unit and instruction memory
module instr_fetch #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    output logic [31:0] instr,
    output logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        fetch_err,
    output logic [31:0] fetch_cnt
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_ISSUE   = 2'd0,
        S_WAIT    = 2'd1,
        S_DELIVER = 2'd2
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  wait_cnt_q;
    logic [31:0]    instr_q;
    logic           stall_q;
    logic           imem_req_q;
    logic [31:0]    imem_addr_q;
    logic           fetch_err_q;
    logic [31:0]    fetch_cnt_q;

    assign instr     = instr_q;
    assign stall     = stall_q;
    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign fetch_err = fetch_err_q;
    assign fetch_cnt = fetch_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ISSUE;
            wait_cnt_q  <= '0;
            instr_q     <= 32'h0;
            stall_q     <= 1'b1;
            imem_req_q  <= 1'b0;
            imem_addr_q <= 32'h0;
            fetch_err_q <= 1'b0;
            fetch_cnt_q <= 32'h0;
        end else begin
            case (state_q)
                S_ISSUE: begin
                    imem_addr_q <= pc;
                    imem_req_q  <= 1'b1;
                    wait_cnt_q  <= '0;
                    instr_q     <= 32'h0;
                    stall_q     <= 1'b1;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    // An ack arriving on the timeout cycle still delivers data.
                    if (imem_ack) begin
                        instr_q     <= imem_rdata;
                        stall_q     <= 1'b0;
                        imem_req_q  <= 1'b0;
                        fetch_cnt_q <= fetch_cnt_q + 32'd1;
                        state_q     <= S_DELIVER;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        instr_q     <= 32'h0;
                        stall_q     <= 1'b0;
                        imem_req_q  <= 1'b0;
                        fetch_err_q <= 1'b1;
                        state_q     <= S_DELIVER;
                    end else begin
                        wait_cnt_q  <= wait_cnt_q + 1'b1;
                    end
                end
                S_DELIVER: begin
                    instr_q <= 32'h0;
                    stall_q <= 1'b1;
                    state_q <= S_ISSUE;
                end
                default: begin
                    instr_q    <= 32'h0;
                    stall_q    <= 1'b1;
                    imem_req_q <= 1'b0;
                    state_q    <= S_ISSUE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        fetch_err;
    logic [31:0] fetch_cnt;

    int tests = 0;
    int fails = 0;

    instr_fetch #(.TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .instr      (instr),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .fetch_err  (fetch_err),
        .fetch_cnt  (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in its first ISSUE cycle with pc=0.
    task automatic apply_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        pc = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        pc = 32'h0;
        tick();
        tick();
        tests++;
        if ({instr, stall, imem_req, imem_addr, fetch_err, fetch_cnt} !== {32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL reset_state: got instr=%h stall=%b req=%b addr=%h err=%b cnt=%0d expected 0/1/0/0/0/0",
                     instr, stall, imem_req, imem_addr, fetch_err, fetch_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_zero_wait();
        apply_reset();
        tick();
        tests++;
        if ({imem_req, imem_addr, stall, instr} !== {1'b1, 32'h0, 1'b1, 32'h0}) begin
            fails++;
            $display("FAIL zw_issue: got req=%b addr=%h stall=%b instr=%h expected 1/0/1/0", imem_req, imem_addr, stall, instr);
        end
        imem_ack = 1'b1;
        imem_rdata = 32'h20080005;
        tick();
        imem_ack = 1'b0;
        tests++;
        if ({instr, stall, imem_req, fetch_cnt} !== {32'h20080005, 1'b0, 1'b0, 32'd1}) begin
            fails++;
            $display("FAIL zw_deliver: got instr=%h stall=%b req=%b cnt=%0d expected 20080005/0/0/1", instr, stall, imem_req, fetch_cnt);
        end
        tick();
        tests++;
        if ({instr, stall, imem_req} !== {32'h0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL zw_after: got instr=%h stall=%b req=%b expected 0/1/0", instr, stall, imem_req);
        end
    endtask

    task automatic test_delayed_ack();
        apply_reset();
        pc = 32'h5;
        tick();
        for (int i = 0; i < 4; i++) begin
            pc = 32'h100 + i;
            tests++;
            if ({imem_req, imem_addr, stall, instr} !== {1'b1, 32'h5, 1'b1, 32'h0}) begin
                fails++;
                $display("FAIL dly_wait%0d: got req=%b addr=%h stall=%b instr=%h expected 1/5/1/0", i, imem_req, imem_addr, stall, instr);
            end
            if (i == 3) begin
                imem_ack = 1'b1;
                imem_rdata = 32'hDEADBEEF;
            end
            tick();
        end
        imem_ack = 1'b0;
        tests++;
        if ({instr, stall, imem_req, fetch_cnt} !== {32'hDEADBEEF, 1'b0, 1'b0, 32'd1}) begin
            fails++;
            $display("FAIL dly_deliver: got instr=%h stall=%b req=%b cnt=%0d expected deadbeef/0/0/1", instr, stall, imem_req, fetch_cnt);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        pc = 32'h7;
        tick();
        for (int i = 0; i < 14; i++) tick();
        tests++;
        if ({imem_req, stall, fetch_err} !== {1'b1, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL to_wait15: got req=%b stall=%b err=%b expected 1/1/0", imem_req, stall, fetch_err);
        end
        tick();
        tests++;
        if ({instr, stall, imem_req, fetch_err, fetch_cnt} !== {32'h0, 1'b0, 1'b0, 1'b1, 32'd0}) begin
            fails++;
            $display("FAIL to_abort: got instr=%h stall=%b req=%b err=%b cnt=%0d expected 0/0/0/1/0",
                     instr, stall, imem_req, fetch_err, fetch_cnt);
        end
        // Stray acks in DELIVER and ISSUE must be ignored.
        imem_ack = 1'b1;
        imem_rdata = 32'h12345678;
        pc = 32'h8;
        tick();
        tick();
        imem_ack = 1'b0;
        tests++;
        if ({instr, stall, imem_req, imem_addr, fetch_err, fetch_cnt} !== {32'h0, 1'b1, 1'b1, 32'h8, 1'b1, 32'd0}) begin
            fails++;
            $display("FAIL to_next_issue: got instr=%h stall=%b req=%b addr=%h err=%b cnt=%0d expected 0/1/1/8/1/0",
                     instr, stall, imem_req, imem_addr, fetch_err, fetch_cnt);
        end
    endtask

    task automatic test_ack_on_timeout();
        apply_reset();
        tick();
        for (int i = 0; i < 14; i++) tick();
        imem_ack = 1'b1;
        imem_rdata = 32'h00000001;
        tick();
        imem_ack = 1'b0;
        tests++;
        if ({instr, stall, fetch_err, fetch_cnt} !== {32'h1, 1'b0, 1'b0, 32'd1}) begin
            fails++;
            $display("FAIL ack_on_timeout: got instr=%h stall=%b err=%b cnt=%0d expected 1/0/0/1", instr, stall, fetch_err, fetch_cnt);
        end
    endtask

    task automatic test_branch();
        logic [31:0] seen;
        apply_reset();
        pc = 32'h4;
        tick();
        imem_ack = 1'b1;
        imem_rdata = 32'h10000003;
        tick();
        imem_ack = 1'b0;
        seen = instr;
        tests++;
        if ({seen, stall} !== {32'h10000003, 1'b0}) begin
            fails++;
            $display("FAIL br_deliver: got instr=%h stall=%b expected 10000003/0", seen, stall);
        end
        // PC unit acts on the delivered beq: pc+1+offset.
        pc = pc + 32'd1 + {{16{seen[15]}}, seen[15:0]};
        tick();
        tests++;
        if ({instr, stall} !== {32'h0, 1'b1}) begin
            fails++;
            $display("FAIL br_stall_nop: got instr=%h stall=%b expected 0/1", instr, stall);
        end
        tick();
        tests++;
        if ({imem_addr, imem_req, instr} !== {32'h8, 1'b1, 32'h0}) begin
            fails++;
            $display("FAIL br_target: got addr=%h req=%b instr=%h expected 8/1/0", imem_addr, imem_req, instr);
        end
        imem_ack = 1'b1;
        imem_rdata = 32'h01095020;
        tick();
        imem_ack = 1'b0;
        pc = pc + 32'd1;
        tick();
        tick();
        tests++;
        if ({imem_addr, fetch_cnt} !== {32'h9, 32'd2}) begin
            fails++;
            $display("FAIL br_seq: got addr=%h cnt=%0d expected 9/2", imem_addr, fetch_cnt);
        end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        tick();
        imem_ack = 1'b1;
        imem_rdata = 32'hAAAA0001;
        tick();
        imem_ack = 1'b0;
        pc = 32'h1;
        tick();
        tick();
        tests++;
        if ({imem_req, imem_addr, fetch_cnt} !== {1'b1, 32'h1, 32'd1}) begin
            fails++;
            $display("FAIL rmw_setup: got req=%b addr=%h cnt=%0d expected 1/1/1", imem_req, imem_addr, fetch_cnt);
        end
        #2;
        rst_n = 1'b0;
        pc = 32'h0;
        #1;
        tests++;
        if ({imem_req, fetch_cnt, imem_addr, stall, instr} !== {1'b0, 32'd0, 32'h0, 1'b1, 32'h0}) begin
            fails++;
            $display("FAIL rmw_async: got req=%b cnt=%0d addr=%h stall=%b instr=%h expected 0/0/0/1/0",
                     imem_req, fetch_cnt, imem_addr, stall, instr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0BAD0;
        tick();
        imem_ack = 1'b0;
        tests++;
        if ({imem_req, imem_addr, instr, fetch_cnt, stall} !== {1'b1, 32'h0, 32'h0, 32'd0, 1'b1}) begin
            fails++;
            $display("FAIL rmw_stray_ack: got req=%b addr=%h instr=%h cnt=%0d stall=%b expected 1/0/0/0/1",
                     imem_req, imem_addr, instr, fetch_cnt, stall);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_delayed_ack();
        test_timeout();
        test_ack_on_timeout();
        test_branch();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
